// File: rtl/sram_like_arbiter.sv
// Two-to-one SRAM-like port arbiter (inst id 0, data id 1) with in-order owner tracking FIFO.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin unlocked arbitration instead of data-over-inst priority.
module sram_like_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic             lock_q;
    logic             lock_id_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [DEPTH-1:0] owner_q;

    logic pick;
    logic grant;
    logic grant_req;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;

    // Contended cycles go to the id not granted last; otherwise whoever asks.
    always_comb begin
        pick = data_sram_req;
        if (inst_sram_req && data_sram_req) begin
            pick = ~last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_q <= 1'b0;
        end else if (push) begin
            last_q <= grant;
        end
    end
`else
    assign pick = data_sram_req;
`endif

    // A stalled address phase keeps its owner until it is accepted.
    assign grant     = lock_q ? lock_id_q : pick;
    assign grant_req = grant ? data_sram_req : inst_sram_req;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);

    assign mem_req   = resetn & grant_req & ~full;
    assign mem_wr    = grant ? data_sram_wr    : inst_sram_wr;
    assign mem_size  = grant ? data_sram_size  : inst_sram_size;
    assign mem_addr  = grant ? data_sram_addr  : inst_sram_addr;
    assign mem_wstrb = grant ? data_sram_wstrb : inst_sram_wstrb;
    assign mem_wdata = grant ? data_sram_wdata : inst_sram_wdata;

    assign push = mem_req & mem_addr_ok;
    assign pop  = resetn & mem_data_ok & ~empty;
    assign head = owner_q[rd_ptr_q];

    assign inst_sram_addr_ok = push & ~grant;
    assign data_sram_addr_ok = push & grant;
    assign inst_sram_data_ok = pop & ~head;
    assign data_sram_data_ok = pop & head;
    assign inst_sram_rdata   = mem_rdata;
    assign data_sram_rdata   = mem_rdata;

    // Owner storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push) begin
            owner_q[wr_ptr_q] <= grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            if (mem_req && !mem_addr_ok) begin
                lock_q    <= 1'b1;
                lock_id_q <= grant;
            end else if (push) begin
                lock_q    <= 1'b0;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed vector bench for sram_like_arbiter (DEPTH=4); follows ARB_ROUND_ROBIN_EN if defined.
module tb_sram_like_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [31:0] IA = 32'h1C00_0004;
    localparam logic [31:0] DA = 32'h0000_1000;
    localparam logic [31:0] Z  = 32'h0;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        rst_n, ireq, dreq, maok, mdok;
        logic [31:0] rdata;
        logic        e_mreq;
        logic [31:0] e_addr;
        logic        e_iaok, e_daok, e_idok, e_ddok;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic ir, input logic dr, input logic ao,
                                input logic dk, input logic [31:0] rd, input logic em,
                                input logic [31:0] ea, input logic eia, input logic eda,
                                input logic eid, input logic edd);
        vec_t v;
        v.rst_n = r; v.ireq = ir; v.dreq = dr; v.maok = ao; v.mdok = dk; v.rdata = rd;
        v.e_mreq = em; v.e_addr = ea; v.e_iaok = eia; v.e_daok = eda;
        v.e_idok = eid; v.e_ddok = edd;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h, want %h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vt[$];

    initial begin
        resetn = 1'b0;
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
        inst_sram_addr = IA; inst_sram_wstrb = 4'h0; inst_sram_wdata = Z;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2;
        data_sram_addr = DA; data_sram_wstrb = 4'h0; data_sram_wdata = Z;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = Z;

        // reset, single inst read
        vt.push_back(mk(0,1,1,1,1,Z,            0,Z, 0,0,0,0));
        vt.push_back(mk(1,1,0,1,0,Z,            1,IA,1,0,0,0));
        vt.push_back(mk(1,0,0,0,0,Z,            0,Z, 0,0,0,0));
        vt.push_back(mk(1,0,0,0,1,32'h1C00_0000,0,Z, 0,0,1,0));
        // contention
        vt.push_back(mk(1,1,1,1,0,Z,            1,DA,0,1,0,0));
        vt.push_back(mk(1,1,0,1,0,Z,            1,IA,1,0,0,0));
        vt.push_back(mk(1,1,1,1,0,Z,            1,DA,0,1,0,0));
        vt.push_back(mk(1,1,1,1,1,32'hAAAA_0001,1,RR ? IA : DA,RR,!RR,0,1));
        vt.push_back(mk(1,0,0,0,1,32'hAAAA_0002,0,Z, 0,0,1,0));
        vt.push_back(mk(1,0,0,0,1,32'hAAAA_0003,0,Z, 0,0,0,1));
        vt.push_back(mk(1,0,0,0,1,32'hAAAA_0004,0,Z, 0,0,RR,!RR));
        // data stalled three cycles, inst joins at cycle 1
        vt.push_back(mk(1,0,1,0,0,Z,            1,DA,0,0,0,0));
        vt.push_back(mk(1,1,1,0,0,Z,            1,DA,0,0,0,0));
        vt.push_back(mk(1,1,1,0,0,Z,            1,DA,0,0,0,0));
        vt.push_back(mk(1,1,1,1,0,Z,            1,DA,0,1,0,0));
        vt.push_back(mk(1,1,0,1,0,Z,            1,IA,1,0,0,0));
        vt.push_back(mk(1,0,0,0,1,32'h5,        0,Z, 0,0,0,1));
        vt.push_back(mk(1,0,0,0,1,32'h6,        0,Z, 0,0,1,0));
        // stalled inst keeps the port against a data request
        vt.push_back(mk(1,1,0,0,0,Z,            1,IA,0,0,0,0));
        vt.push_back(mk(1,1,1,0,0,Z,            1,IA,0,0,0,0));
        vt.push_back(mk(1,1,1,1,0,Z,            1,IA,1,0,0,0));
        vt.push_back(mk(1,1,1,1,0,Z,            1,DA,0,1,0,0));
        vt.push_back(mk(1,0,0,0,1,32'h7,        0,Z, 0,0,1,0));
        vt.push_back(mk(1,0,0,0,1,32'h8,        0,Z, 0,0,0,1));
        // fill the FIFO, no lookahead on pop
        for (int i = 0; i < 4; i++) vt.push_back(mk(1,1,0,1,0,Z,1,IA,1,0,0,0));
        vt.push_back(mk(1,1,0,1,0,Z,            0,Z, 0,0,0,0));
        vt.push_back(mk(1,1,0,1,1,32'h9,        0,Z, 0,0,1,0));
        vt.push_back(mk(1,1,0,1,0,Z,            1,IA,1,0,0,0));
        for (int i = 0; i < 4; i++) vt.push_back(mk(1,0,0,0,1,32'h10 + i,0,Z,0,0,1,0));
        // interleaved inst, data, inst
        vt.push_back(mk(1,1,0,1,0,Z,            1,IA,1,0,0,0));
        vt.push_back(mk(1,0,1,1,0,Z,            1,DA,0,1,0,0));
        vt.push_back(mk(1,1,0,1,0,Z,            1,IA,1,0,0,0));
        vt.push_back(mk(1,0,0,0,1,32'h11,       0,Z, 0,0,1,0));
        vt.push_back(mk(1,0,0,0,1,32'h22,       0,Z, 0,0,0,1));
        vt.push_back(mk(1,0,0,0,1,32'h33,       0,Z, 0,0,1,0));
        // spurious responses on empty, reset mid-burst
        vt.push_back(mk(1,0,0,0,1,32'h44,       0,Z, 0,0,0,0));
        vt.push_back(mk(1,0,0,0,1,32'h44,       0,Z, 0,0,0,0));
        vt.push_back(mk(1,1,0,1,0,Z,            1,IA,1,0,0,0));
        vt.push_back(mk(1,0,1,1,0,Z,            1,DA,0,1,0,0));
        vt.push_back(mk(0,1,1,1,1,Z,            0,Z, 0,0,0,0));
        vt.push_back(mk(1,0,0,0,1,32'h55,       0,Z, 0,0,0,0));
        vt.push_back(mk(1,1,0,1,0,Z,            1,IA,1,0,0,0));
        vt.push_back(mk(1,0,0,0,1,32'h66,       0,Z, 0,0,1,0));

        tick();
        tick();
        foreach (vt[i]) begin
            resetn        = vt[i].rst_n;
            inst_sram_req = vt[i].ireq;
            data_sram_req = vt[i].dreq;
            mem_addr_ok   = vt[i].maok;
            mem_data_ok   = vt[i].mdok;
            mem_rdata     = vt[i].rdata;
            #3;
            check("mem_req",      i, 32'(mem_req),           32'(vt[i].e_mreq));
            if (vt[i].e_mreq) check("mem_addr", i, mem_addr, vt[i].e_addr);
            check("inst_addr_ok", i, 32'(inst_sram_addr_ok), 32'(vt[i].e_iaok));
            check("data_addr_ok", i, 32'(data_sram_addr_ok), 32'(vt[i].e_daok));
            check("inst_data_ok", i, 32'(inst_sram_data_ok), 32'(vt[i].e_idok));
            check("data_data_ok", i, 32'(data_sram_data_ok), 32'(vt[i].e_ddok));
            if (vt[i].e_idok) check("inst_rdata", i, inst_sram_rdata, vt[i].rdata);
            if (vt[i].e_ddok) check("data_rdata", i, data_sram_rdata, vt[i].rdata);
            tick();
        end

        // data write stalled: every forwarded field held while inst waits
        resetn = 1'b1; mem_data_ok = 1'b0; mem_addr_ok = 1'b0; inst_sram_req = 1'b0;
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_size = 2'd1;
        data_sram_addr = 32'h0000_2000; data_sram_wstrb = 4'b0011; data_sram_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) inst_sram_req = 1'b1;
            #3;
            check("wr_hold_req",   100 + c, 32'(mem_req),   32'd1);
            check("wr_hold_wr",    100 + c, 32'(mem_wr),    32'd1);
            check("wr_hold_size",  100 + c, 32'(mem_size),  32'd1);
            check("wr_hold_addr",  100 + c, mem_addr,       32'h0000_2000);
            check("wr_hold_wstrb", 100 + c, 32'(mem_wstrb), 32'h3);
            check("wr_hold_wdata", 100 + c, mem_wdata,      32'hDEAD_BEEF);
            check("wr_hold_iaok",  100 + c, 32'(inst_sram_addr_ok), 32'd0);
            tick();
        end
        mem_addr_ok = 1'b1;
        #3;
        check("wr_accept_daok", 103, 32'(data_sram_addr_ok), 32'd1);
        check("wr_accept_iaok", 103, 32'(inst_sram_addr_ok), 32'd0);
        tick();
        data_sram_req = 1'b0; inst_sram_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        #3;
        check("wr_resp_ddok", 104, 32'(data_sram_data_ok), 32'd1);
        check("wr_resp_idok", 104, 32'(inst_sram_data_ok), 32'd0);
        tick();
        mem_data_ok = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-to-one arbiter sharing a single SRAM-like memory port between the IF-stage instruction requester and the EXE/MEM-stage data requester of the pipelined CPU. It sits between the `mycpu_top` pipeline ports (`inst_sram_*`, `data_sram_*`) and the downstream memory/bridge port (`mem_*`). It grants one address phase per cycle, holds the grant until accepted, and records the owner of every accepted transaction in an in-order tracking FIFO. Each `mem_data_ok`/`mem_rdata` is steered back to the requester that issued it.

## Interface
- `DEPTH`, 4, max outstanding accepted-but-not-completed transactions (power of two, ≥2)
- `clk`  in  1  clock
- `resetn`  in  1  reset, synchronous, active-low
- `inst_sram_req / wr`  in  1 each  instruction request, write flag
- `inst_sram_size`  in  2  transfer size
- `inst_sram_addr`  in  32  address
- `inst_sram_wstrb`  in  4  byte strobes
- `inst_sram_wdata`  in  32  write data
- `inst_sram_addr_ok / data_ok`  out  1 each  address accepted; response
- `inst_sram_rdata`  out  32  read data
- `data_sram_*`  same set, same directions and widths as `inst_sram_*`
- `mem_req / wr`  out  1 each  forwarded request
- `mem_size`  out  2
- `mem_addr`  out  32
- `mem_wstrb`  out  4
- `mem_wdata`  out  32
- `mem_addr_ok / data_ok`  in  1 each
- `mem_rdata`  in  32

## Operation
- Grant select:
  - If `lock`=1, grant = `lock_id`.
  - Otherwise choose among the asserted requests by priority: data (id 1) over inst (id 0).
- `mem_*` request fields are muxed from the granted requester.
- `mem_req` = granted req & !fifo_full.
- Address acceptance:
  - Granted requester's `addr_ok` = `mem_addr_ok` & `mem_req`. Non-granted `addr_ok` = 0.
- Lock:
  - When `mem_req`=1 and `mem_addr_ok`=0, set `lock`=1 and `lock_id`=grant.
  - Clear `lock` on the cycle the locked request is accepted.
  - Result: a presented request never switches source mid-handshake.
- Tracking FIFO, DEPTH entries × 1 bit (owner id):
  - Push the grant id on `mem_req & mem_addr_ok`.
  - Pop on `mem_data_ok` when not empty.
  - Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Response routing:
  - `X_data_ok` = `mem_data_ok` & !empty & (head == X).
  - Both `rdata` outputs = `mem_rdata`; they are qualified only by their own `data_ok`.
- Ordering: responses return in acceptance order. The downstream port guarantees in-order completion.

## Timing
- Reset values (`resetn`=0 at posedge):
  - count=0, rd/wr pointers=0, `lock`=0, `lock_id`=0, round-robin pointer=0.
  - All `addr_ok`/`data_ok`/`mem_req` = 0 while in reset.
- `addr_ok` and `data_ok` are combinational pass-throughs: 0-cycle latency. Arbitration adds no cycle.
- FIFO boundaries:
  - Full: `mem_req` forced 0 even if a pop occurs the same cycle. No lookahead.
  - Empty + `mem_data_ok`: ignored. No pop, no `data_ok` to either side. Count stays 0.
- Simultaneous push and pop with not full, not empty: count unchanged, both pointers advance.
- Both requesters asserting: one `addr_ok` per cycle, never both.
- Reset mid-operation: all in-flight tracking discarded. Pipeline flush is handled by the pipeline, not here.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Unlocked arbitration uses a 1-bit round-robin pointer favouring the id not granted last.
  - The pointer updates on each accepted request.
- Undefined: fixed data-over-inst priority. No pointer register.

## Test plan
- Single inst read, `mem_addr_ok` same cycle, `mem_data_ok` 2 cycles later with `mem_rdata`=0x1C000000 -> `inst_sram_addr_ok`=1 that cycle; `inst_sram_data_ok`=1 with rdata 0x1C000000; `data_sram_data_ok` stays 0.
- Both req, data addr 0x1000, inst addr 0x1C000004, `mem_addr_ok` always 1:
  - Fixed priority: data accepted cycle 0, inst cycle 1.
  - With `ARB_ROUND_ROBIN_EN`: alternation across 4 cycles.
- Data req with `mem_addr_ok` low for 3 cycles; inst req raised at cycle 1 -> `mem_addr`=0x1000 held stable all 3 cycles; inst waits until data accepted.
- DEPTH=4, 4 accepted inst reads, no `data_ok` -> fifth req sees `mem_req`=0; after one `mem_data_ok`, next cycle `mem_req`=1.
- Interleaved accept order inst,data,inst then three `mem_data_ok` -> `data_ok` pulses inst, data, inst in that order.
- `mem_data_ok` with empty FIFO -> no `data_ok` on either side. `resetn`=0 mid-burst -> count 0 next cycle, a following `mem_data_ok` is ignored.
